// File: rtl/uart_baud_engine.sv
// Fractional baud-tick generator: shadowed integer+fraction divisor with atomic
// commit, and independent tx/rx tick channels with per-channel enables.

module uart_baud_channel #(
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4,
    parameter bit HALF_START = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              start,
    input  logic [DIV_W-1:0]  active_div,
    input  logic [FRAC_W-1:0] active_frac,
    output logic              tick
);

    logic [DIV_W:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0] acc_sum;
    logic [DIV_W:0]  reload_val;
    logic [DIV_W:0]  start_val;

    // The fractional carry stretches one period by a cycle, so the reload can
    // reach div+1; cnt carries one extra bit for that.
    assign acc_sum    = {1'b0, acc} + {1'b0, active_frac};
    assign reload_val = {1'b0, active_div} + {{DIV_W{1'b0}}, acc_sum[FRAC_W]};
    assign start_val  = HALF_START ? {2'b00, active_div[DIV_W-1:1]}
                                   : {1'b0, active_div};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            acc  <= '0;
            tick <= 1'b0;
        end else if (!en) begin
            cnt  <= {1'b0, active_div};
            acc  <= '0;
            tick <= 1'b0;
        end else if (start) begin
            cnt  <= start_val;
            acc  <= '0;
            tick <= 1'b0;
        end else if (cnt == '0) begin
            tick <= 1'b1;
            acc  <= acc_sum[FRAC_W-1:0];
            cnt  <= reload_val;
        end else begin
            cnt  <= cnt - (DIV_W+1)'(1);
            tick <= 1'b0;
        end
    end

    // A tick can only follow an enabled, non-restarted cycle whose count was zero.
    a_tick_cause: assert property (@(posedge clk) disable iff (!rst_n)
        tick |-> $past(en && !start && (cnt == '0)));

endmodule

module uart_baud_engine #(
    parameter int          DIV_W      = 16,
    parameter int          FRAC_W     = 4,
    parameter int unsigned RESET_DIV  = 326,
    parameter int unsigned RESET_FRAC = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_we,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_wdata,
    input  logic       tx_start,
    input  logic       rx_start,
    output logic       tx_tick,
    output logic       rx_tick
);

    localparam logic [DIV_W-1:0]  RST_DIV  = DIV_W'(RESET_DIV);
    localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(RESET_FRAC);

    logic [7:0]        shadow_lo;
    logic [FRAC_W-1:0] shadow_frac;
    logic [DIV_W-1:0]  active_div;
    logic [FRAC_W-1:0] active_frac;
    logic [1:0]        en;

    // cfg_we is a plain write strobe with no back-pressure: every cycle it is
    // high performs exactly one write of cfg_wdata to cfg_addr on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_lo   <= RST_DIV[7:0];
            shadow_frac <= RST_FRAC;
            active_div  <= RST_DIV;
            active_frac <= RST_FRAC;
            en          <= 2'b11;
        end else if (cfg_we) begin
            case (cfg_addr)
                2'd0: shadow_lo <= cfg_wdata;
                2'd1: begin
                    // High byte write commits integer and fraction together.
                    active_div  <= {cfg_wdata[DIV_W-9:0], shadow_lo};
                    active_frac <= shadow_frac;
                end
                2'd2: shadow_frac <= cfg_wdata[FRAC_W-1:0];
                default: en <= cfg_wdata[1:0];
            endcase
        end
    end

    uart_baud_channel #(
        .DIV_W      (DIV_W),
        .FRAC_W     (FRAC_W),
        .HALF_START (1'b0)
    ) u_tx (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en[0]),
        .start       (tx_start),
        .active_div  (active_div),
        .active_frac (active_frac),
        .tick        (tx_tick)
    );

    uart_baud_channel #(
        .DIV_W      (DIV_W),
        .FRAC_W     (FRAC_W),
        .HALF_START (1'b1)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en[1]),
        .start       (rx_start),
        .active_div  (active_div),
        .active_frac (active_frac),
        .tick        (rx_tick)
    );

endmodule

// File: tb/tb_uart_baud_engine.sv
// Directed bench for uart_baud_engine: tick spacing, divisor commit timing,
// enables, start/zero collisions and asynchronous reset.

module tb_uart_baud_engine;

    localparam int LIMIT = 400;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = 2'd0;
    logic [7:0] cfg_wdata = 8'd0;
    logic       tx_start = 1'b0;
    logic       rx_start = 1'b0;
    logic       tx_tick;
    logic       rx_tick;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    uart_baud_engine #(
        .DIV_W      (16),
        .FRAC_W     (4),
        .RESET_DIV  (326),
        .RESET_FRAC (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .tx_start  (tx_start),
        .rx_start  (rx_start),
        .tx_tick   (tx_tick),
        .rx_tick   (rx_tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // All driver tasks are entered 1ns after a rising edge and return there.
    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic pulse_tx();
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
    endtask

    task automatic pulse_rx();
        rx_start = 1'b1;
        @(posedge clk);
        #1;
        rx_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Edges until the selected tick is seen high; -1 if the budget runs out.
    task automatic wait_tick(input bit rx, output int k);
        k = -1;
        for (int i = 1; i <= LIMIT; i++) begin
            @(posedge clk);
            #1;
            if ((rx ? rx_tick : tx_tick) === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic count_ticks(input int n, output int txc, output int rxc);
        txc = 0;
        rxc = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (tx_tick === 1'b1) txc++;
            if (rx_tick === 1'b1) rxc++;
        end
    endtask

    task automatic check_gaps(input bit rx, input string tag);
        int k;
        int idx;
        logic [31:0] e;
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_tick(rx, k);
            check($sformatf("%s_%0d", tag, idx), k, e);
            idx++;
        end
    endtask

    initial begin
        int k;
        int txc;
        int rxc;

        // reset state and free-running ticks from reset
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx_tick", {31'd0, tx_tick}, 32'd0);
        check("reset_rx_tick", {31'd0, rx_tick}, 32'd0);
        rst_n = 1'b1;
        wait_tick(1'b0, k);
        check("reset_first_tx", k, 32'd1);
        check("reset_first_rx_same", {31'd0, rx_tick}, 32'd1);
        idle(1);
        check("tick_one_cycle", {31'd0, tx_tick}, 32'd0);
        wait_tick(1'b0, k);
        check("free_run_period", k, 32'd326);

        // start alignment with D=326
        pulse_tx();
        wait_tick(1'b0, k);
        check("tx_start_327", k, 32'd327);
        pulse_rx();
        wait_tick(1'b1, k);
        check("rx_start_164", k, 32'd164);
        wait_tick(1'b1, k);
        check("rx_full_period", k, 32'd327);

        // D=3, frac=8/16: spacing 4,4,5,4,5 from the start edge
        cfg_write(2'd0, 8'h03);
        cfg_write(2'd2, 8'h08);
        cfg_write(2'd1, 8'h00);
        pulse_tx();
        exp_q.push_back(32'd4);
        exp_q.push_back(32'd4);
        exp_q.push_back(32'd5);
        exp_q.push_back(32'd4);
        exp_q.push_back(32'd5);
        check_gaps(1'b0, "frac_gap");

        // back to 326, then a low-byte shadow write alone must not alter timing
        cfg_write(2'd0, 8'h46);
        cfg_write(2'd2, 8'h00);
        cfg_write(2'd1, 8'h01);
        cfg_write(2'd0, 8'h51);
        pulse_tx();
        exp_q.push_back(32'd327);
        exp_q.push_back(32'd327);
        check_gaps(1'b0, "shadow_only");
        // commit one edge after a tick: current period still ends at 327
        cfg_write(2'd1, 8'h00);
        exp_q.push_back(32'd326);
        exp_q.push_back(32'd82);
        exp_q.push_back(32'd82);
        check_gaps(1'b0, "commit_81");

        // commit landing on the reload edge: reload still uses 81
        cfg_write(2'd0, 8'h09);
        idle(80);
        cfg_write(2'd1, 8'h00);
        check("commit_on_reload_tick", {31'd0, tx_tick}, 32'd1);
        exp_q.push_back(32'd82);
        exp_q.push_back(32'd10);
        check_gaps(1'b0, "commit_on_reload");

        // tx_start on the cnt==0 edge wins over the tick
        idle(9);
        pulse_tx();
        check("tx_start_vs_zero", {31'd0, tx_tick}, 32'd0);
        wait_tick(1'b0, k);
        check("tx_after_collision", k, 32'd10);

        // same for rx with half-period reload
        pulse_rx();
        wait_tick(1'b1, k);
        check("rx_half_d9", k, 32'd5);
        idle(9);
        pulse_rx();
        check("rx_start_vs_zero", {31'd0, rx_tick}, 32'd0);
        wait_tick(1'b1, k);
        check("rx_after_collision", k, 32'd5);

        // rx disabled: no ticks, rx_start ignored, tx unaffected
        cfg_write(2'd3, 8'h01);
        pulse_rx();
        count_ticks(40, txc, rxc);
        check("rx_disabled_ticks", rxc, 32'd0);
        check("tx_while_rx_off", txc, 32'd4);
        cfg_write(2'd3, 8'h03);
        wait_tick(1'b1, k);
        check("rx_reenable", k, 32'd10);

        // disabling tx mid-period drops the pending tick
        wait_tick(1'b0, k);
        cfg_write(2'd3, 8'h02);
        count_ticks(30, txc, rxc);
        check("tx_disabled_ticks", txc, 32'd0);
        check("rx_while_tx_off", rxc, 32'd3);
        cfg_write(2'd3, 8'h03);
        wait_tick(1'b0, k);
        check("tx_reenable", k, 32'd10);

        // D=0, frac=0: tick every cycle
        cfg_write(2'd0, 8'h00);
        cfg_write(2'd2, 8'h00);
        cfg_write(2'd1, 8'h00);
        pulse_tx();
        count_ticks(20, txc, rxc);
        check("div0_every_cycle", txc, 32'd20);

        // D=81, frac=5, then asynchronous reset while a tick is high
        cfg_write(2'd0, 8'h51);
        cfg_write(2'd2, 8'h05);
        cfg_write(2'd1, 8'h00);
        pulse_tx();
        exp_q.push_back(32'd82);
        exp_q.push_back(32'd82);
        check_gaps(1'b0, "d81_f5");
        check("pre_reset_tick", {31'd0, tx_tick}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_tx", {31'd0, tx_tick}, 32'd0);
        check("async_reset_rx", {31'd0, rx_tick}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_tick(1'b0, k);
        check("post_reset_first_tx", k, 32'd1);
        check("post_reset_rx_enabled", {31'd0, rx_tick}, 32'd1);
        wait_tick(1'b0, k);
        check("post_reset_period", k, 32'd327);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
